pc_register: RTL and testbench
==============================

Name: pc_register

Overview:
- Program-counter state register at the front of the SIMD AES pipeline fetch stage.
- Captures the next-PC value from the fetch/branch logic on every rising clock edge.
- Presents the captured value as the current PC to instruction memory and the IF/ID stage.
- Pure storage element: no increment, no branch resolution inside the block.

Parameters:
- PC_WIDTH, 11, width in bits of the PC (2048-entry instruction address space).
- RESET_PC, 11'd0, value loaded into the PC on reset (boot vector).

Ports:
- clock, input, 1, single system clock; all state updates on its rising edge.
- reset_n, input, 1, reset; synchronous, active-low.
- pc_in, input, PC_WIDTH, next-PC value from fetch/branch mux.
- pc_out, output, PC_WIDTH, current registered PC.

Behaviour:
- One clock; reset is synchronous and active-low. There are no asynchronous paths.
- Reset:
  - On a rising edge of clock with reset_n == 0, pc_out becomes RESET_PC (0).
  - pc_in is ignored during that cycle.
  - Reset has priority over the load.
- Load:
  - On a rising edge with reset_n == 1, pc_out takes the value pc_in had just before the edge.
  - Latency is exactly 1 cycle.
- Between edges:
  - pc_out is stable.
  - Changes on pc_in have no effect until the next rising edge; there is no combinational path from pc_in to pc_out.
- Width:
  - pc_in is loaded verbatim (full PC_WIDTH bits).
  - No wrap-around or arithmetic is performed. Incrementing and wrap from 2047 to 0 are the caller's responsibility.
- Reset mid-operation:
  - Asserting reset_n low for one edge forces RESET_PC regardless of the prior value.
  - The first edge after release loads pc_in.
- Power-up:
  - pc_out is undefined (X in simulation) until the first reset edge or the first load edge.
  - RTL does not rely on an initial value.
- Implementation: a single always_ff on posedge clock with nonblocking assignments.

Decomposition:
- Shared pipeline package:
  - PC_WIDTH constant (11).
  - Typedef pc_t = logic [PC_WIDTH-1:0].
  - RESET_PC constant.
- Use pc_t for pc_in and pc_out.
- No sub-module. The block is a single flop bank.

Test Plan:
- Reset: reset_n = 0, pc_in = 11'd555, one rising edge -> pc_out = 0.
- Basic load: reset_n = 1, pc_in = 0 for 2 edges, then pc_in = 1024 set mid-cycle -> pc_out = 0 until the next rising edge, then 1024 from one edge onward.
- No combinational path: change pc_in 7 -> 9 between edges -> pc_out holds its previous value until the next edge, then 9.
- Full range: load 0, then 2047, then 1 on consecutive edges -> pc_out = 0, 2047, 1 one cycle after each; no truncation.
- Reset priority and mid-operation: pc_out = 1024, reset_n = 0 with pc_in = 300 at an edge -> pc_out = 0; release reset_n -> next edge gives pc_out = 300.
- Back-to-back: pc_in = 1, 2, 3, 4 changing every cycle -> pc_out follows with exactly 1-cycle lag: 1, 2, 3, 4.

Source files
------------

// File: rtl/pc_register_pkg.sv
// Shared fetch-pipeline definitions: PC width, PC type and boot vector.
package pc_register_pkg;

  localparam int PC_WIDTH = 11;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t RESET_PC = '0;

endpackage

// File: rtl/pc_register.sv
// Program-counter flop bank at the front of the fetch stage.
// Increment and wrap are done by the caller; this block only stores the next-PC.
module pc_register
  import pc_register_pkg::*;
#(
  parameter pc_t RESET_PC = pc_register_pkg::RESET_PC
) (
  input  logic clock,
  input  logic reset_n,
  input  pc_t  pc_in,
  output pc_t  pc_out
);

  // Synchronous reset takes priority over the load on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_out <= RESET_PC;
    end else begin
      pc_out <= pc_in;
    end
  end

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register: directed vector table, a mid-cycle
// stability sequence, and randomized traffic against a behavioural model.
module tb_pc_register;
  import pc_register_pkg::*;

  logic clock;
  logic reset_n;
  pc_t  pc_in;
  pc_t  pc_out;

  int checks;
  int failures;

  pc_register dut (
    .clock   (clock),
    .reset_n (reset_n),
    .pc_in   (pc_in),
    .pc_out  (pc_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rst_n;
    pc_t  din;
    pc_t  exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input pc_t act, input pc_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: pc_out=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Apply inputs while the clock is low, take one rising edge, return at the
  // following falling edge so outputs are sampled well away from the edge.
  task automatic cycle(input logic r, input pc_t d);
    reset_n = r;
    pc_in   = d;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    pc_t model;
    logic r;
    pc_t d;

    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    pc_in    = '0;

    vecs[0]  = '{1'b0, 11'd555,  11'd0};
    vecs[1]  = '{1'b1, 11'd0,    11'd0};
    vecs[2]  = '{1'b1, 11'd0,    11'd0};
    vecs[3]  = '{1'b1, 11'd1024, 11'd1024};
    vecs[4]  = '{1'b1, 11'd1024, 11'd1024};
    vecs[5]  = '{1'b0, 11'd300,  11'd0};
    vecs[6]  = '{1'b1, 11'd300,  11'd300};
    vecs[7]  = '{1'b1, 11'd0,    11'd0};
    vecs[8]  = '{1'b1, 11'd2047, 11'd2047};
    vecs[9]  = '{1'b1, 11'd1,    11'd1};
    vecs[10] = '{1'b1, 11'd2,    11'd2};
    vecs[11] = '{1'b1, 11'd3,    11'd3};
    vecs[12] = '{1'b1, 11'd4,    11'd4};
    vecs[13] = '{1'b0, 11'd2047, 11'd0};
    vecs[14] = '{1'b1, 11'd1365, 11'd1365};
    vecs[15] = '{1'b1, 11'd682,  11'd682};

    @(negedge clock);

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].rst_n, vecs[i].din);
      check($sformatf("vec%0d", i), pc_out, vecs[i].exp);
    end

    // Basic load with mid-cycle change: 1024 appears only after the next edge.
    cycle(1'b1, 11'd0);
    cycle(1'b1, 11'd0);
    check("load_zero", pc_out, 11'd0);
    #2 pc_in = 11'd1024;
    #1 check("mid_cycle_hold", pc_out, 11'd0);
    @(posedge clock);
    @(negedge clock);
    check("mid_cycle_load", pc_out, 11'd1024);

    // pc_in toggling between edges must not reach pc_out combinationally.
    cycle(1'b1, 11'd5);
    check("pre_toggle", pc_out, 11'd5);
    pc_in = 11'd7;
    #2 pc_in = 11'd9;
    #1 check("no_comb_path", pc_out, 11'd5);
    @(posedge clock);
    @(negedge clock);
    check("toggle_load", pc_out, 11'd9);

    // Randomized traffic: output equals the previous edge's input, or the boot
    // vector when reset was low at that edge.
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(9) != 0);
      d = pc_t'($urandom_range(2047));
      model = r ? d : RESET_PC;
      cycle(r, d);
      check("random", pc_out, model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
